// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit constant into a 20/18/17-bit immediate field (optional hi/lo split).
// Latency: first beat one cycle after acceptance; split requests add a second beat.
// Backpressure: out_* hold while out_ready=0; in_ready only in IDLE or when the last beat is consumed.
// Build option: define IMM_SPLIT_EN to emit non-fitting values as two beats instead of an error beat.
module imm_encoder #(
  parameter int FIELD_W = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_value,
  input  logic [1:0]         in_imm_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic [1:0]         out_imm_src,
  output logic               out_last,
  output logic               out_err,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EMIT, EMIT_LO} state_t;

  state_t state;

  logic               take;
  logic               accept;
  logic               fit;
  logic [19:0]        low20;
  logic [FIELD_W-1:0] n_field;
  logic [1:0]         n_src;
  logic               n_last;
  logic               n_err;
`ifdef IMM_SPLIT_EN
  logic [11:0]        n_lo;
  logic [11:0]        lo_q;
`endif

  assign out_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign take      = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | (take & out_last);
  assign accept    = in_valid & in_ready;

  // Build the first beat of an incoming request straight from the request inputs.
  always_comb begin
    fit     = 1'b0;
    low20   = '0;
    n_field = '0;
    n_src   = in_imm_src;
    n_last  = 1'b1;
    n_err   = 1'b0;
`ifdef IMM_SPLIT_EN
    n_lo    = '0;
`endif
    case (in_imm_src)
      2'b00: begin
        fit   = (&in_value[31:19]) | ~(|in_value[31:19]);
        low20 = in_value[19:0];
      end
      2'b01: begin
        fit   = (&in_value[31:17]) | ~(|in_value[31:17]);
        low20 = {2'b00, in_value[17:0]};
      end
      2'b10: begin
        fit   = (&in_value[31:16]) | ~(|in_value[31:16]);
        low20 = {3'b000, in_value[16:0]};
      end
      default: begin
        fit   = 1'b0;
        low20 = '0;
      end
    endcase
    n_field = FIELD_W'(low20);
    if (in_imm_src == 2'b11) begin
      n_field = '0;
      n_err   = 1'b1;
    end else if (!fit) begin
`ifdef IMM_SPLIT_EN
      // Upper 20 bits go first in the 20-bit format; the low 12 bits follow.
      n_field = FIELD_W'(in_value[31:12]);
      n_src   = 2'b00;
      n_last  = 1'b0;
      n_lo    = in_value[11:0];
`else
      n_field = '0;
      n_err   = 1'b1;
`endif
    end
  end

  // Request FSM with registered beat outputs; a consumed last beat can overlap a new acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_field   <= '0;
      out_imm_src <= 2'b00;
      out_last    <= 1'b0;
      out_err     <= 1'b0;
`ifdef IMM_SPLIT_EN
      lo_q        <= '0;
`endif
    end else if (accept) begin
      state       <= EMIT;
      out_field   <= n_field;
      out_imm_src <= n_src;
      out_last    <= n_last;
      out_err     <= n_err;
`ifdef IMM_SPLIT_EN
      lo_q        <= n_lo;
`endif
    end else if (take) begin
      if (out_last) begin
        state <= IDLE;
      end
`ifdef IMM_SPLIT_EN
      else begin
        state       <= EMIT_LO;
        out_field   <= FIELD_W'(lo_q);
        out_imm_src <= 2'b00;
        out_last    <= 1'b1;
        out_err     <= 1'b0;
      end
`endif
    end
  end

endmodule
